// File: rtl/rng_pkg.sv
// Shared types and helpers for the card dealer RNG.
// Seed table: seed k = 16'hACE1 ^ (k * 16'h9E37); a zero result becomes 1.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        DRAW
    } state_t;

    function automatic logic [15:0] seed_table(input int unsigned k);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(k * 32'h9E37);
        if (s == 16'h0) begin
            s = 16'h1;
        end
        return s;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rng_lfsr.sv
// Galois LFSR (right shift) with synchronous reset value, load and step.
// Only the low OUT_W bits are exposed as the random output.
module rng_lfsr
    import rng_pkg::*;
#(
    parameter int               W         = 16,
    parameter logic [W-1:0]     TAPS      = 16'hB400,
    parameter logic [W-1:0]     RESET_VAL = 16'hACE1,
    parameter int               OUT_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     seed,
    output logic [OUT_W-1:0] rnd
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
        end
    end

    assign rnd = q[OUT_W-1:0];

endmodule

// File: rtl/card_dealer_rng.sv
// No-repeat card dealer driven by a seedable Galois LFSR.
// Define RNG_AUTO_RESHUFFLE_EN to reshuffle implicitly on an empty-deck request.
module card_dealer_rng
    import rng_pkg::*;
#(
    parameter int                DECK_SIZE = 52,
    parameter int                CARD_W    = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int                NUM_SEEDS = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           shuffle_i,
    input  logic                           request_card_i,
    output logic                           card_valid_o,
    output logic [CARD_W-1:0]              card_o,
    output logic [$clog2(DECK_SIZE+1)-1:0] cards_left_o,
    output logic                           deck_empty_o,
    output logic                           busy_o
);

    localparam int IDX_W = idx_width(DECK_SIZE);
    localparam int CL_W  = $clog2(DECK_SIZE + 1);
    localparam int SC_W  = idx_width(NUM_SEEDS);

    localparam logic [IDX_W:0]  DECK_N = (IDX_W + 1)'(DECK_SIZE);
    localparam logic [CL_W-1:0] FULL   = CL_W'(DECK_SIZE);

    function automatic logic [LFSR_W-1:0] fit_seed(input logic [15:0] s);
        logic [LFSR_W-1:0] t;
        t = LFSR_W'(s);
        return (t == '0) ? LFSR_W'(1) : t;
    endfunction

    localparam logic [LFSR_W-1:0] SEED0 = fit_seed(seed_table(0));

    state_t                 state;
    logic [SC_W-1:0]        seed_cnt;
    logic [LFSR_W-1:0]      seed_sel;
    logic [IDX_W-1:0]       rnd;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       c;
    logic [IDX_W-1:0]       c_nxt;
    logic [DECK_SIZE-1:0]   dealt;
    logic                   lfsr_load;
    logic                   lfsr_step;

    assign seed_sel  = fit_seed(seed_table(32'(seed_cnt)));
    assign lfsr_load = (state != DRAW) && start_i;
    assign lfsr_step = (state != IDLE);

    rng_lfsr #(
        .W         (LFSR_W),
        .TAPS      (LFSR_TAPS),
        .RESET_VAL (SEED0),
        .OUT_W     (IDX_W)
    ) u_lfsr (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (seed_sel),
        .rnd  (rnd)
    );

    // Fold an out-of-range index back once; the probe walk fixes collisions.
    assign cand = ({1'b0, rnd} >= DECK_N) ? (rnd - DECK_N[IDX_W-1:0]) : rnd;

    assign c_nxt = (({1'b0, c} + (IDX_W + 1)'(1)) == DECK_N) ? '0
                 : (c + IDX_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            seed_cnt     <= '0;
            card_o       <= '0;
            card_valid_o <= 1'b0;
            cards_left_o <= '0;
            deck_empty_o <= 1'b1;
            busy_o       <= 1'b1;
            dealt        <= '0;
            c            <= '0;
        end else begin
            if (32'(seed_cnt) == NUM_SEEDS - 1) begin
                seed_cnt <= '0;
            end else begin
                seed_cnt <= seed_cnt + SC_W'(1);
            end
            card_valid_o <= 1'b0;
            card_o       <= '0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        dealt        <= '0;
                        cards_left_o <= FULL;
                        deck_empty_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= READY;
                    end
                end
                READY: begin
                    if (start_i || shuffle_i) begin
                        dealt        <= '0;
                        cards_left_o <= FULL;
                        deck_empty_o <= 1'b0;
                    end else if (request_card_i) begin
                        if (cards_left_o != '0) begin
                            c      <= cand;
                            busy_o <= 1'b1;
                            state  <= DRAW;
                        end else begin
`ifdef RNG_AUTO_RESHUFFLE_EN
                            dealt        <= '0;
                            cards_left_o <= FULL;
                            deck_empty_o <= 1'b0;
                            c            <= cand;
                            busy_o       <= 1'b1;
                            state        <= DRAW;
`else
                            card_valid_o <= 1'b1;
`endif
                        end
                    end
                end
                DRAW: begin
                    if (!dealt[c]) begin
                        dealt[c]     <= 1'b1;
                        cards_left_o <= cards_left_o - CL_W'(1);
                        deck_empty_o <= (cards_left_o == CL_W'(1));
                        card_o       <= CARD_W'(c) + CARD_W'(1);
                        card_valid_o <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= READY;
                    end else begin
                        c <= c_nxt;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer_rng.sv
// Scoreboard bench for card_dealer_rng: stimulus queues expectations,
// a forked monitor pops and compares on every card_valid_o strobe.
module tb_card_dealer_rng;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       shuffle_i = 1'b0;
    logic       request_card_i = 1'b0;
    logic       card_valid_o;
    logic [7:0] card_o;
    logic [5:0] cards_left_o;
    logic       deck_empty_o;
    logic       busy_o;

    typedef struct {
        int card;
        int left;
        bit clr;
    } exp_t;

    exp_t sb[$];
    bit   seen[0:255];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    card_dealer_rng dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .shuffle_i      (shuffle_i),
        .request_card_i (request_card_i),
        .card_valid_o   (card_valid_o),
        .card_o         (card_o),
        .cards_left_o   (cards_left_o),
        .deck_empty_o   (deck_empty_o),
        .busy_o         (busy_o)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic chk_range(input string nm, input int act,
                             input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   cv;
        forever begin
            @(negedge clk);
            if (card_valid_o === 1'b1) begin
                cv = int'(card_o);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: card %0d, required none", cv);
                end else begin
                    e = sb.pop_front();
                    if (e.clr) begin
                        seen = '{default: 1'b0};
                    end
                    if (e.card < 0) begin
                        n_checks++;
                        if (cv < 1 || cv > 52 || seen[cv]) begin
                            n_fail++;
                            $display("FAIL card_unique: got %0d, required new card 1..52", cv);
                        end
                    end else begin
                        chk("card", cv, e.card);
                    end
                    seen[cv] = 1'b1;
                    chk("cards_left", int'(cards_left_o), e.left);
                end
            end
        end
    endtask

    // Called right after a negedge; issues one request and waits for its strobe.
    task automatic draw(input int card, input int left, input bit clr,
                        input int lo, input int hi, input bit poke);
        int n;
        int lat;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        sb.push_back('{card, left, clr});
        request_card_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            request_card_i = poke && (lat == 1);
        end while (!card_valid_o && lat < 60);
        request_card_i = 1'b0;
        chk_range("latency", lat, lo, hi);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none

        do_reset();
        chk("rst_busy", int'(busy_o), 1);
        chk("rst_empty", int'(deck_empty_o), 1);
        chk("rst_left", int'(cards_left_o), 0);
        chk("rst_valid", int'(card_valid_o), 0);
        chk("rst_card", int'(card_o), 0);

        rst_i = 1'b0;
        request_card_i = 1'b1;
        @(negedge clk);
        request_card_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy_o), 1);
        chk("idle_left", int'(cards_left_o), 0);

        // Start at seed counter 0: hand-traced cards 34, 5, 15.
        do_reset();
        rst_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_left", int'(cards_left_o), 52);
        chk("start_empty", int'(deck_empty_o), 0);
        chk("start_busy", int'(busy_o), 0);
        draw(34, 51, 1'b1, 2, 2, 1'b0);
        draw(5, 50, 1'b0, 2, 2, 1'b0);
        draw(15, 49, 1'b0, 2, 2, 1'b0);
        for (int i = 3; i < 52; i++) begin
            draw(-1, 51 - i, 1'b0, 2, 53, 1'b0);
        end
        chk("deal_empty", int'(deck_empty_o), 1);

`ifdef RNG_AUTO_RESHUFFLE_EN
        draw(-1, 51, 1'b1, 2, 53, 1'b0);
        chk("reshuffle_empty", int'(deck_empty_o), 0);
        chk("reshuffle_busy", int'(busy_o), 0);
`else
        draw(0, 0, 1'b0, 1, 1, 1'b0);
        chk("empty_flag", int'(deck_empty_o), 1);
        chk("empty_busy", int'(busy_o), 0);
`endif

        // start beats a same-cycle request: no strobe, full deck.
        start_i = 1'b1;
        request_card_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        request_card_i = 1'b0;
        chk("prio_left", int'(cards_left_o), 52);
        chk("prio_busy", int'(busy_o), 0);
        repeat (4) @(negedge clk);

        // Extra request during DRAW must be ignored.
        draw(-1, 51, 1'b1, 2, 53, 1'b1);
        repeat (5) @(negedge clk);
        chk("draw_ignore_left", int'(cards_left_o), 51);

        for (int i = 0; i < 9; i++) begin
            draw(-1, 50 - i, 1'b0, 2, 53, 1'b0);
        end
        shuffle_i = 1'b1;
        @(negedge clk);
        shuffle_i = 1'b0;
        chk("shuffle_left", int'(cards_left_o), 52);
        chk("shuffle_empty", int'(deck_empty_o), 0);
        for (int i = 0; i < 52; i++) begin
            draw(-1, 51 - i, i == 0, 2, 53, 1'b0);
        end
        chk("redeal_empty", int'(deck_empty_o), 1);

        // Start at seed counter 1: hand-traced cards 23, 2, 46.
        do_reset();
        rst_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        draw(23, 51, 1'b1, 2, 2, 1'b0);
        draw(2, 50, 1'b0, 2, 2, 1'b0);
        draw(46, 49, 1'b0, 2, 2, 1'b0);

        // Same offset as before reproduces the seed-0 sequence.
        do_reset();
        rst_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        draw(34, 51, 1'b1, 2, 2, 1'b0);
        draw(5, 50, 1'b0, 2, 2, 1'b0);
        draw(15, 49, 1'b0, 2, 2, 1'b0);

        // Reset in the middle of a draw emits nothing.
        request_card_i = 1'b1;
        @(negedge clk);
        request_card_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_left", int'(cards_left_o), 0);
        chk("abort_busy", int'(busy_o), 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
